// File: rtl/instr_queue_pkg.sv
// Shared fetch/decode types: the fetched packet layout and the fetch-to-queue bundle.
// Also holds the pop-amount helper used by the queue control.
// Pure declarations; no latency or flow control of its own.
package instr_queue_pkg;

    localparam int DEF_PC_BITS    = 32;
    localparam int DEF_INSTR_BITS = 32;
    localparam int PKT_W          = DEF_PC_BITS + DEF_INSTR_BITS + 1;

    typedef struct packed {
        logic [DEF_PC_BITS-1:0]    pc;
        logic [DEF_INSTR_BITS-1:0] data;
        logic                      taken_branch;
    } fetched_packet;

    // Fetch stage delivers two packets per beat; packet_a is the older one.
    typedef struct packed {
        fetched_packet packet_b;
        fetched_packet packet_a;
    } if_pair_t;

    // Entries removed this cycle: a pop_b alone, or a pop on an empty slot, removes nothing.
    function automatic logic [1:0] pop_amount(input logic pop_a, input logic pop_b,
                                              input logic valid_a, input logic valid_b);
        if (pop_a && pop_b && valid_b) return 2'd2;
        if (pop_a && valid_a)          return 2'd1;
        return 2'd0;
    endfunction

endpackage

// File: rtl/iq_storage.sv
// Packet storage array: two write ports, two read ports, no reset.
// Write visible the cycle after the write edge; reads are combinational.
// No flow control; the caller guarantees writes only target free entries.
module iq_storage
    import instr_queue_pkg::*;
#(
    parameter int W     = PKT_W,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr_a,
    input  logic [AW-1:0] waddr_b,
    input  logic [W-1:0]  wdat_a,
    input  logic [W-1:0]  wdat_b,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdat_a,
    output logic [W-1:0]  rdat_b
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr_a] <= wdat_a;
            mem[waddr_b] <= wdat_b;
        end
    end

    assign rdat_a = mem[raddr_a];
    assign rdat_b = mem[raddr_b];

endmodule

// File: rtl/instr_queue.sv
// Instruction queue between fetch (two packets per push) and decode (pops one or two).
// Pushed packets appear at the outputs one cycle after the push edge.
// ready_out needs two free entries from registered count; refused pushes are dropped and counted.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int PC_BITS     = 32,
    parameter int INSTR_BITS  = 32,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [2*(PC_BITS+INSTR_BITS+1)-1:0]     data_in,
    input  logic                                    valid_in,
    output logic                                    ready_out,
    input  logic                                    flush,
    output logic [PC_BITS+INSTR_BITS:0]             packet_a_out,
    output logic [PC_BITS+INSTR_BITS:0]             packet_b_out,
    output logic                                    valid_a_o,
    output logic                                    valid_b_o,
    input  logic                                    pop_a,
    input  logic                                    pop_b,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]        count,
    output logic [31:0]                             stall_cycles
);

    localparam int PW = PC_BITS + INSTR_BITS + 1;
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic [1:0]    popped;

    assign ready_out = (32'(count) + 32'd2) <= 32'(QUEUE_DEPTH);
    assign valid_a_o = (count != '0) && !flush;
    assign valid_b_o = (count >= CW'(2)) && !flush;
    assign push      = valid_in && ready_out && !flush;
    assign popped    = pop_amount(pop_a, pop_b, valid_a_o, valid_b_o);

    // Depth is a power of two, so pointer arithmetic wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            stall_cycles <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(popped);
            tail  <= push ? tail + AW'(2) : tail;
            count <= count + (push ? CW'(2) : CW'(0)) - CW'(popped);
            if (valid_in && !ready_out && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    iq_storage #(
        .W     (PW),
        .DEPTH (QUEUE_DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .we      (push && !rst),
        .waddr_a (tail),
        .waddr_b (tail + AW'(1)),
        .wdat_a  (data_in[PW-1:0]),
        .wdat_b  (data_in[2*PW-1:PW]),
        .raddr_a (head),
        .raddr_b (head + AW'(1)),
        .rdat_a  (packet_a_out),
        .rdat_b  (packet_b_out)
    );

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed scenarios then random traffic, checked every cycle
// against a queue-based reference model of the occupancy and packet order.
module tb_instr_queue;
    import instr_queue_pkg::*;

    localparam int D  = 8;
    localparam int CW = $clog2(D+1);

    logic                 clk = 1'b0;
    logic                 rst, valid_in, ready_out, flush, pop_a, pop_b;
    logic                 valid_a_o, valid_b_o;
    logic [2*PKT_W-1:0]   data_in;
    logic [PKT_W-1:0]     packet_a_out, packet_b_out;
    logic [CW-1:0]        count;
    logic [31:0]          stall_cycles;

    always #5 clk = ~clk;

    instr_queue #(
        .PC_BITS     (DEF_PC_BITS),
        .INSTR_BITS  (DEF_INSTR_BITS),
        .QUEUE_DEPTH (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .flush        (flush),
        .packet_a_out (packet_a_out),
        .packet_b_out (packet_b_out),
        .valid_a_o    (valid_a_o),
        .valid_b_o    (valid_b_o),
        .pop_a        (pop_a),
        .pop_b        (pop_b),
        .count        (count),
        .stall_cycles (stall_cycles)
    );

    logic [PKT_W-1:0] mq[$];
    logic [31:0]      mstall;
    bit               known = 0;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk(input logic [31:0] pc);
        fetched_packet p;
        p.pc           = pc;
        p.data         = $urandom;
        p.taken_branch = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic drv(input bit v, input logic [31:0] pc, input bit f,
                       input bit pa, input bit pb, input bit r);
        valid_in = v;
        data_in  = {mk(pc + 32'd4), mk(pc)};
        flush    = f;
        pop_a    = pa;
        pop_b    = pb;
        rst      = r;
    endtask

    // Check outputs against the model mid-cycle, then advance the model across the edge.
    task automatic cycle();
        int n;
        bit rdy, va, vb;
        @(negedge clk);
        n   = mq.size();
        rdy = (D - n) >= 2;
        va  = (n >= 1) && !flush;
        vb  = (n >= 2) && !flush;
        if (known) begin
            chk("count", 128'(count), 128'(n));
            chk("ready_out", 128'(ready_out), 128'(rdy));
            chk("valid_a", 128'(valid_a_o), 128'(va));
            chk("valid_b", 128'(valid_b_o), 128'(vb));
            if (va) chk("packet_a", 128'(packet_a_out), 128'(mq[0]));
            if (vb) chk("packet_b", 128'(packet_b_out), 128'(mq[1]));
            chk("stall_cycles", 128'(stall_cycles), 128'(mstall));
        end
        if (rst) begin
            mq.delete();
            mstall = 0;
            known  = 1;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (pop_a && pop_b && vb) begin
                void'(mq.pop_front());
                void'(mq.pop_front());
            end else if (pop_a && va) begin
                void'(mq.pop_front());
            end
            if (valid_in && rdy) begin
                mq.push_back(data_in[PKT_W-1:0]);
                mq.push_back(data_in[2*PKT_W-1:PKT_W]);
            end else if (valid_in && mstall != 32'hFFFF_FFFF) begin
                mstall = mstall + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_of(input logic [PKT_W-1:0] p);
        return p[PKT_W-1 -: 32];
    endfunction

    initial begin
        drv(0, 0, 0, 0, 0, 1);
        cycle();

        // Basic push, visible next cycle.
        drv(1, 32'h100, 0, 0, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0);
        chk("first_pc_a", 128'(pc_of(packet_a_out)), 128'h100);
        chk("first_pc_b", 128'(pc_of(packet_b_out)), 128'h104);
        chk("first_count", 128'(count), 128'd2);
        cycle();

        // Fill to full, then a dropped push.
        drv(1, 32'h110, 0, 0, 0, 0); cycle();
        drv(1, 32'h120, 0, 0, 0, 0); cycle();
        drv(1, 32'h130, 0, 0, 0, 0); cycle();
        chk("full_count", 128'(count), 128'd8);
        chk("full_ready", 128'(ready_out), 128'd0);
        drv(1, 32'h140, 0, 0, 0, 0); cycle();
        chk("stall_one", 128'(stall_cycles), 128'd1);

        // Drain to head=6 with two entries left; pop_b alone is ignored.
        drv(0, 0, 0, 1, 1, 0); cycle(); cycle(); cycle();
        drv(0, 0, 0, 0, 1, 0); cycle();
        drv(0, 0, 0, 0, 0, 0);
        chk("popb_only_count", 128'(count), 128'd2);
        chk("popb_only_pc", 128'(pc_of(packet_a_out)), 128'h130);

        // Wrap: push while popping two at count=6.
        drv(1, 32'h1e0, 0, 0, 0, 0); cycle();
        drv(1, 32'h1f0, 0, 0, 0, 0); cycle();
        drv(1, 32'h200, 0, 1, 1, 0); cycle();
        drv(0, 0, 0, 0, 0, 0);
        chk("wrap_count", 128'(count), 128'd6);
        chk("wrap_pc_a", 128'(pc_of(packet_a_out)), 128'h1e0);
        drv(0, 0, 0, 1, 0, 0); cycle();
        chk("five_count", 128'(count), 128'd5);

        // Flush overrides push and pop.
        drv(1, 32'h400, 1, 1, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0);
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_valid_a", 128'(valid_a_o), 128'd0);
        chk("flush_ready", 128'(ready_out), 128'd1);
        cycle();

        // Mid-stream reset with a stall count pending.
        drv(1, 32'h500, 0, 0, 0, 0); cycle(); cycle(); cycle(); cycle(); cycle();
        drv(0, 0, 0, 1, 0, 0); cycle(); cycle(); cycle(); cycle();
        chk("pre_rst_count", 128'(count), 128'd4);
        drv(1, 32'h600, 0, 1, 1, 1); cycle();
        drv(0, 0, 0, 0, 0, 0);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_stall", 128'(stall_cycles), 128'd0);
        chk("rst_ready", 128'(ready_out), 128'd1);
        drv(1, 32'h300, 0, 0, 0, 0); cycle();
        drv(0, 0, 0, 0, 0, 0);
        chk("post_rst_pc_a", 128'(pc_of(packet_a_out)), 128'h300);
        chk("post_rst_pc_b", 128'(pc_of(packet_b_out)), 128'h304);
        cycle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drv($urandom_range(0, 9) < 6, {$urandom_range(0, 16'hffff), 2'b00},
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 79) == 0);
            cycle();
        end
        drv(0, 0, 0, 0, 0, 0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
